// File: rtl/peak_sorter.sv
// Keeps the three strongest distinct code-phase peaks from the accumulator maximum stream,
// merging adjacent phases, and posts one detect verdict against noise_floor x threshold.
module peak_sorter #(
  parameter int PEAK_NUM = 3,
  parameter int POS_W    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [7:0]       in_amp,
  input  logic [3:0]       in_exp,
  input  logic [POS_W-1:0] in_pos,
  input  logic [2:0]       in_freq,
  input  logic [17:0]      noise_floor,
  input  logic [7:0]       threshold,
  input  logic             search_done,
  output logic [7:0]       peak_amp0,
  output logic [7:0]       peak_amp1,
  output logic [7:0]       peak_amp2,
  output logic [3:0]       peak_exp0,
  output logic [3:0]       peak_exp1,
  output logic [3:0]       peak_exp2,
  output logic [POS_W-1:0] peak_pos0,
  output logic [POS_W-1:0] peak_pos1,
  output logic [POS_W-1:0] peak_pos2,
  output logic [2:0]       peak_frq0,
  output logic [2:0]       peak_frq1,
  output logic [2:0]       peak_frq2,
  output logic [1:0]       peak_cnt,
  output logic             result_valid,
  output logic             detected,
  output logic             busy
);

  typedef struct packed {
    logic             vld;
    logic [22:0]      norm;
    logic [7:0]       amp;
    logic [3:0]       exp;
    logic [POS_W-1:0] pos;
    logic [2:0]       frq;
  } ent_t;

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DECIDE} state_t;

  localparam logic [POS_W:0] ONE = (POS_W+1)'(1);

  state_t                   state_q, state_d;
  ent_t                     s0_q, s0_d;
  ent_t [PEAK_NUM-1:0]      lst_q, lst_d;
  logic [3:0]               nf_exp_q, nf_exp_d;
  logic                     det_q, det_d;
  logic                     rv_q, rv_d;

  logic                     accept;
  logic [PEAK_NUM-1:0]      adj;
  logic [1:0]               rank, hole;
  logic                     rank_ok, mrg, drop;
  logic [26:0]              lhs;
  logic [40:0]              nf_sh, rhs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      s0_q     <= '0;
      lst_q    <= '0;
      nf_exp_q <= '0;
      det_q    <= 1'b0;
      rv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      s0_q     <= s0_d;
      lst_q    <= lst_d;
      nf_exp_q <= nf_exp_d;
      det_q    <= det_d;
      rv_q     <= rv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) state_d = COLLECT;
    else begin
      case (state_q)
        COLLECT: if (search_done) state_d = DRAIN;
        DRAIN:   state_d = DECIDE;
        DECIDE:  state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // S0: register the honoured candidate with its normalised magnitude
  always_comb begin
    accept   = in_valid && (state_q == COLLECT) && !clear;
    s0_d     = '0;
    nf_exp_d = clear ? 4'd0 : nf_exp_q;
    if (accept) begin
      s0_d.vld  = 1'b1;
      s0_d.norm = 23'(in_amp) << in_exp;
      s0_d.amp  = in_amp;
      s0_d.exp  = in_exp;
      s0_d.pos  = in_pos;
      s0_d.frq  = in_freq;
      nf_exp_d  = in_exp;
    end
  end

  // S1: rank is the first slot the candidate beats; hole is the slot vacated by the shift
  // (the merged entry, or the last slot which falls off)
  always_comb begin
    adj     = '0;
    rank    = '0;
    rank_ok = 1'b0;
    hole    = 2'(PEAK_NUM-1);
    mrg     = 1'b0;
    for (int k = 0; k < PEAK_NUM; k++)
      adj[k] = lst_q[k].vld &&
               (({1'b0, s0_q.pos} == {1'b0, lst_q[k].pos}) ||
                ({1'b0, s0_q.pos} == {1'b0, lst_q[k].pos} + ONE) ||
                ({1'b0, lst_q[k].pos} == {1'b0, s0_q.pos} + ONE));
    for (int j = PEAK_NUM-1; j >= 0; j--) begin
      if (!lst_q[j].vld || (lst_q[j].norm < s0_q.norm)) begin
        rank    = 2'(j);
        rank_ok = 1'b1;
      end
      if (adj[j]) begin
        hole = 2'(j);
        mrg  = 1'b1;
      end
    end
    drop = !s0_q.vld || (mrg ? (s0_q.norm <= lst_q[hole].norm) : !rank_ok);

    lst_d = lst_q;
    if (clear) lst_d = '0;
    else if (!drop) begin
      for (int j = 0; j < PEAK_NUM; j++)
        if (j == int'(rank)) lst_d[j] = s0_q;
      for (int j = 1; j < PEAK_NUM; j++)
        if ((j > int'(rank)) && (j <= int'(hole))) lst_d[j] = lst_q[j-1];
    end
  end

  always_comb begin
    lhs   = {lst_q[0].norm, 4'b0000};
    nf_sh = 41'(noise_floor) << nf_exp_q;
    rhs   = nf_sh * {33'b0, threshold};
    rv_d  = (state_q == DECIDE) && !clear;
    det_d = det_q;
    if (clear) det_d = 1'b0;
    else if (state_q == DECIDE) det_d = lst_q[0].vld && ({14'b0, lhs} >= rhs);
  end

  assign peak_amp0    = lst_q[0].amp;
  assign peak_amp1    = lst_q[1].amp;
  assign peak_amp2    = lst_q[2].amp;
  assign peak_exp0    = lst_q[0].exp;
  assign peak_exp1    = lst_q[1].exp;
  assign peak_exp2    = lst_q[2].exp;
  assign peak_pos0    = lst_q[0].pos;
  assign peak_pos1    = lst_q[1].pos;
  assign peak_pos2    = lst_q[2].pos;
  assign peak_frq0    = lst_q[0].frq;
  assign peak_frq1    = lst_q[1].frq;
  assign peak_frq2    = lst_q[2].frq;
  assign peak_cnt     = {1'b0, lst_q[0].vld} + {1'b0, lst_q[1].vld} + {1'b0, lst_q[2].vld};
  assign result_valid = rv_q;
  assign detected     = det_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_peak_sorter.sv
// Directed bench for peak_sorter: queue-based reference model checked every cycle,
// plus literal expectations at the interesting points.
module tb_peak_sorter;

  logic        clk = 0;
  logic        rst = 1;
  logic        clear = 0, in_valid = 0, search_done = 0;
  logic [7:0]  in_amp = 0;
  logic [3:0]  in_exp = 0;
  logic [9:0]  in_pos = 0;
  logic [2:0]  in_freq = 0;
  logic [17:0] noise_floor = 0;
  logic [7:0]  threshold = 0;
  logic [7:0]  peak_amp0, peak_amp1, peak_amp2;
  logic [3:0]  peak_exp0, peak_exp1, peak_exp2;
  logic [9:0]  peak_pos0, peak_pos1, peak_pos2;
  logic [2:0]  peak_frq0, peak_frq1, peak_frq2;
  logic [1:0]  peak_cnt;
  logic        result_valid, detected, busy;

  peak_sorter dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_amp(in_amp),
    .in_exp(in_exp), .in_pos(in_pos), .in_freq(in_freq), .noise_floor(noise_floor),
    .threshold(threshold), .search_done(search_done),
    .peak_amp0(peak_amp0), .peak_amp1(peak_amp1), .peak_amp2(peak_amp2),
    .peak_exp0(peak_exp0), .peak_exp1(peak_exp1), .peak_exp2(peak_exp2),
    .peak_pos0(peak_pos0), .peak_pos1(peak_pos1), .peak_pos2(peak_pos2),
    .peak_frq0(peak_frq0), .peak_frq1(peak_frq1), .peak_frq2(peak_frq2),
    .peak_cnt(peak_cnt), .result_valid(result_valid), .detected(detected), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int amp; int exp; int pos; int frq; longint norm; } pk_t;

  int     tests = 0, fails = 0;
  bit     started = 0;
  pk_t    lst[$];
  pk_t    pend;
  bit     pend_v = 0;
  bit     m_collect = 0, m_busy = 0, m_det = 0, m_rv = 0;
  int     m_nfexp = 0;
  longint ecount = 0, decide_at = -1;

  task automatic check(string nm, longint act, longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    lst.delete(); pend_v = 0; m_collect = 0; m_busy = 0; m_det = 0; m_rv = 0;
    m_nfexp = 0; decide_at = -1;
  endtask

  task automatic apply(pk_t c);
    int k, j, d;
    k = -1;
    foreach (lst[i]) begin
      d = c.pos - lst[i].pos;
      if (k < 0 && d >= -1 && d <= 1) k = i;
    end
    if (k >= 0) begin
      if (c.norm <= lst[k].norm) return;
      lst.delete(k);
    end
    j = lst.size();
    for (int i = lst.size() - 1; i >= 0; i--)
      if (lst[i].norm < c.norm) j = i;
    if (j >= 3) return;
    lst.insert(j, c);
    if (lst.size() > 3) void'(lst.pop_back());
  endtask

  task automatic model_step();
    pk_t c;
    longint rhs;
    ecount++;
    if (rst) begin model_reset(); return; end
    m_rv = 0;
    if (clear) begin
      model_reset(); m_collect = 1; m_busy = 1;
      return;
    end
    if (decide_at == ecount) begin
      rhs = (longint'(noise_floor) << m_nfexp) * longint'(threshold);
      m_det = (lst.size() > 0) && (lst[0].norm * 16 >= rhs);
      m_rv = 1; m_busy = 0; decide_at = -1;
    end
    if (pend_v) apply(pend);
    pend_v = 0;
    if (m_collect && in_valid) begin
      c.amp = in_amp; c.exp = in_exp; c.pos = in_pos; c.frq = in_freq;
      c.norm = longint'(in_amp) << in_exp;
      pend = c; pend_v = 1; m_nfexp = in_exp;
    end
    if (m_collect && search_done) begin
      m_collect = 0; decide_at = ecount + 2;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic longint mf(int i, int f);
    if (i >= lst.size()) return 0;
    case (f)
      0: return lst[i].amp;
      1: return lst[i].exp;
      2: return lst[i].pos;
      default: return lst[i].frq;
    endcase
  endfunction

  initial forever begin
    @(negedge clk);
    if (started) begin
      check("amp0", peak_amp0, mf(0,0)); check("amp1", peak_amp1, mf(1,0));
      check("amp2", peak_amp2, mf(2,0));
      check("exp0", peak_exp0, mf(0,1)); check("exp1", peak_exp1, mf(1,1));
      check("exp2", peak_exp2, mf(2,1));
      check("pos0", peak_pos0, mf(0,2)); check("pos1", peak_pos1, mf(1,2));
      check("pos2", peak_pos2, mf(2,2));
      check("frq0", peak_frq0, mf(0,3)); check("frq1", peak_frq1, mf(1,3));
      check("frq2", peak_frq2, mf(2,3));
      check("cnt", peak_cnt, lst.size());
      check("result_valid", result_valid, m_rv);
      check("detected", detected, m_det);
      check("busy", busy, m_busy);
    end
  end

  task automatic set_cand(int a, int e, int p, int f);
    in_valid = 1; in_amp = 8'(a); in_exp = 4'(e); in_pos = 10'(p); in_freq = 3'(f);
  endtask

  task automatic send(int a, int e, int p, int f);
    set_cand(a, e, p, f); tick(); in_valid = 0;
  endtask

  task automatic do_clear();
    clear = 1; tick(); clear = 0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // search_done pulse; verdict must appear exactly three cycles later
  task automatic finish_search(string nm, logic exp_det);
    search_done = 1; tick(); search_done = 0;
    check({nm, "_rv_t1"}, result_valid, 0);
    tick(); check({nm, "_rv_t2"}, result_valid, 0);
    tick(); check({nm, "_rv_t3"}, result_valid, 1);
    check({nm, "_det"}, detected, exp_det);
    tick(); check({nm, "_rv_after"}, result_valid, 0);
    check({nm, "_det_hold"}, detected, exp_det);
    check({nm, "_busy_idle"}, busy, 0);
  endtask

  int pa[4] = '{10, 40, 20, 30};
  int pp[4] = '{5, 100, 300, 500};

  initial begin
    model_reset();
    idle(2);
    started = 1;
    check("rst_cnt", peak_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_rv", result_valid, 0);
    rst = 0;
    idle(2);

    // four unrelated peaks, back to back
    do_clear();
    for (int i = 0; i < 4; i++) begin
      set_cand(pa[i], 0, pp[i], i);
      tick();
      if (i == 0) check("lat_cnt_early", peak_cnt, 0);
      if (i == 1) begin
        check("lat_cnt", peak_cnt, 1);
        check("lat_pos0", peak_pos0, 5);
      end
    end
    in_valid = 0;
    idle(2);
    check("s1_pos0", peak_pos0, 100);
    check("s1_pos1", peak_pos1, 500);
    check("s1_pos2", peak_pos2, 300);
    check("s1_cnt", peak_cnt, 3);

    // adjacent merge, then adjacent weaker candidate dropped
    do_clear();
    send(50, 0, 200, 1); send(60, 0, 201, 2); idle(2);
    check("mrg_cnt", peak_cnt, 1);
    check("mrg_pos0", peak_pos0, 201);
    check("mrg_amp0", peak_amp0, 60);
    send(55, 0, 202, 3); idle(2);
    check("mrg_drop_amp0", peak_amp0, 60);
    check("mrg_drop_cnt", peak_cnt, 1);
    // merge that reorders: 70@203 replaces 60@201? no: adjacency is to 202 only -> new entry
    send(70, 0, 203, 0); send(90, 0, 204, 0); idle(2);

    // exponent-aware compare and tie-keeps-rank
    do_clear();
    send(200, 0, 10, 0); send(13, 4, 20, 0); idle(2);
    check("exp_pos0", peak_pos0, 20);
    check("exp_exp0", peak_exp0, 4);
    check("exp_pos1", peak_pos1, 10);
    do_clear();
    send(1, 4, 40, 0); send(16, 0, 30, 0); idle(2);
    check("tie_pos0", peak_pos0, 40);
    check("tie_pos1", peak_pos1, 30);
    // full list, candidate equal to entry 2 is dropped
    send(5, 0, 60, 0); send(5, 0, 80, 0); idle(2);
    check("full_tie_pos2", peak_pos2, 60);

    // verdicts: exact boundary and one below
    noise_floor = 100; threshold = 8'h30;
    do_clear();
    send(75, 2, 50, 0); send(1, 0, 400, 0);
    finish_search("thr300", 1);
    noise_floor = 80;
    do_clear(); send(240, 0, 7, 0); finish_search("thr240", 1);
    do_clear(); send(239, 0, 7, 0); finish_search("thr239", 0);
    do_clear(); send(75, 2, 7, 0); finish_search("thr_nfexp", 0);
    search_done = 1; tick(); search_done = 0; idle(3);
    check("sd_idle_busy", busy, 0);

    // clear wins over a same-cycle candidate
    do_clear();
    clear = 1; set_cand(99, 0, 9, 0); tick(); clear = 0; in_valid = 0;
    idle(3);
    check("clr_drop_cnt", peak_cnt, 0);

    // reset during DRAIN
    send(100, 0, 7, 0);
    search_done = 1; tick(); search_done = 0;
    rst = 1; model_reset(); #1;
    check("rst_drain_cnt", peak_cnt, 0);
    check("rst_drain_busy", busy, 0);
    check("rst_drain_amp0", peak_amp0, 0);
    idle(2); rst = 0; idle(5);

    // empty search
    do_clear();
    finish_search("empty", 0);
    check("empty_cnt", peak_cnt, 0);
    idle(2);

    started = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
